// File: rtl/cv32e40s_pkg.sv
// Shared cv32e40s types used by the PMP scan checker: PMP CSR layout,
// access/privilege encodings, scan FSM states and the permission helpers.
package cv32e40s_pkg;

    localparam int PMP_MAX_REGIONS = 64;
    localparam int PMP_ADDR_W      = 32;  // pmpaddr holds byte address bits [33:2]

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } privlvl_t;

    typedef enum logic {
        SECURITY_LVL_NS = 1'b0,
        SECURITY_LVL_S  = 1'b1
    } security_lvl_t;

    typedef enum logic [1:0] {
        PMP_ACC_EXEC  = 2'b00,
        PMP_ACC_WRITE = 2'b01,
        PMP_ACC_READ  = 2'b10
    } pmp_req_e;

    typedef enum logic [1:0] {
        PMP_MODE_OFF   = 2'b00,
        PMP_MODE_TOR   = 2'b01,
        PMP_MODE_NA4   = 2'b10,
        PMP_MODE_NAPOT = 2'b11
    } pmp_cfg_mode_e;

    typedef struct packed {
        logic          lock;
        logic [1:0]    zero0;
        pmp_cfg_mode_e mode;
        logic          exec;
        logic          write;
        logic          read;
    } pmpncfg_t;

    typedef struct packed {
        logic [28:0] zero0;
        logic        rlb;
        logic        mmwp;
        logic        mml;
    } mseccfg_t;

    typedef struct packed {
        pmpncfg_t [PMP_MAX_REGIONS-1:0]                  cfg;
        logic     [PMP_MAX_REGIONS-1:0][PMP_ADDR_W-1:0]  addr;
        mseccfg_t                                        mseccfg;
    } pmp_csr_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        RESP = 2'b10
    } pmp_scan_state_e;

    // Permission granted by one matching region (MML table or legacy rules).
    function automatic logic pmp_perm_ok(input pmpncfg_t cfg, input logic is_m,
                                         input logic mml, input pmp_req_e t);
        logic       r, w, x, ok;
        logic [3:0] lrwx;
        lrwx = {cfg.lock, cfg.read, cfg.write, cfg.exec};
        r = cfg.read;
        w = cfg.write;
        x = cfg.exec;
        if (mml) begin
            r = 1'b0;
            w = 1'b0;
            x = 1'b0;
            case (lrwx)
                4'b0001: x = !is_m;
                4'b0010: begin r = 1'b1; w = is_m; end
                4'b0011: begin r = 1'b1; w = 1'b1; end
                4'b0100: r = !is_m;
                4'b0101: begin r = !is_m; x = !is_m; end
                4'b0110: begin r = !is_m; w = !is_m; end
                4'b0111: begin r = !is_m; w = !is_m; x = !is_m; end
                4'b1001: x = is_m;
                4'b1010: x = 1'b1;
                4'b1011: begin r = is_m; x = 1'b1; end
                4'b1100: r = is_m;
                4'b1101: begin r = is_m; x = is_m; end
                4'b1110: begin r = is_m; w = is_m; end
                4'b1111: r = 1'b1;
                default: ;
            endcase
        end else if (is_m && !cfg.lock) begin
            r = 1'b1;
            w = 1'b1;
            x = 1'b1;
        end
        case (t)
            PMP_ACC_READ:  ok = r;
            PMP_ACC_WRITE: ok = w;
            default:       ok = x;
        endcase
        return ok;
    endfunction

    // Outcome when no region matches.
    function automatic logic pmp_default_fault(input logic is_m, input mseccfg_t m,
                                               input pmp_req_e t);
        logic f;
        if (!is_m)       f = 1'b1;
        else if (m.mmwp) f = 1'b1;
        else             f = m.mml && (t == PMP_ACC_EXEC);
        return f;
    endfunction

endpackage

// File: rtl/cv32e40s_pmp_region_check.sv
// Combinational address match and permission check for a single PMP region.
module cv32e40s_pmp_region_check
    import cv32e40s_pkg::*;
#(
    parameter int PMP_GRANULARITY = 0,
    parameter int ADDR_WIDTH      = 34
) (
    input  pmpncfg_t                cfg_i,
    input  logic [PMP_ADDR_W-1:0]   addr_i,
    input  logic [PMP_ADDR_W-1:0]   prev_addr_i,
    input  logic                    is_region0_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  pmp_req_e                req_type_i,
    input  privlvl_t                priv_lvl_i,
    input  logic                    mml_i,
    output logic                    match_o,
    output logic                    fault_o
);
    localparam int AW = ADDR_WIDTH - 2;  // word-address width

    logic [AW-1:0] a_w, p_w, lo_w, a_g, p_g, lo_g, napot_mask;
    logic          ones;
    logic          unused_bits;

    assign a_w  = req_addr_i[ADDR_WIDTH-1:2];
    assign p_w  = addr_i[AW-1:0];
    assign lo_w = is_region0_i ? '0 : prev_addr_i[AW-1:0];
    assign a_g  = a_w  >> PMP_GRANULARITY;
    assign p_g  = p_w  >> PMP_GRANULARITY;
    assign lo_g = lo_w >> PMP_GRANULARITY;
    assign unused_bits = ^req_addr_i[1:0];

    // Bits at or below the granule are always masked; above it, a bit is
    // masked only while every pmpaddr bit beneath it (down to the granule) is 1.
    always_comb begin
        ones          = 1'b1;
        napot_mask    = '0;
        napot_mask[0] = 1'b1;
        for (int j = 1; j < AW; j++) begin
            if (j > PMP_GRANULARITY) ones = ones & p_w[j-1];
            napot_mask[j] = ones;
        end
    end

    always_comb begin
        match_o = 1'b0;
        case (cfg_i.mode)
            PMP_MODE_TOR:   match_o = (a_g >= lo_g) && (a_g < p_g);
            PMP_MODE_NA4:   match_o = (a_g == p_g);
            PMP_MODE_NAPOT: match_o = (((a_w ^ p_w) & ~napot_mask) == '0);
            default:        match_o = 1'b0;
        endcase
    end

    assign fault_o = !pmp_perm_ok(cfg_i, priv_lvl_i == PRIV_LVL_M, mml_i, req_type_i);

endmodule

// File: rtl/cv32e40s_pmp_scan.sv
// Multi-cycle PMP checker: walks the region set REGIONS_PER_CYCLE entries per
// cycle, stops at the first matching group and reports the lowest hit.
module cv32e40s_pmp_scan
    import cv32e40s_pkg::*;
#(
    parameter int  PMP_GRANULARITY   = 0,
    parameter int  PMP_NUM_REGIONS   = 16,
    parameter int  REGIONS_PER_CYCLE = 4,
    parameter int  ADDR_WIDTH        = 34,
    localparam int RIDX_W            = (PMP_NUM_REGIONS > 1) ? $clog2(PMP_NUM_REGIONS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  pmp_csr_t              csr_pmp_i,
    input  logic                  csr_pmp_wr_i,
    input  privlvl_t              priv_lvl_i,
    input  security_lvl_t         security_lvl_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  pmp_req_e              req_type_i,
    input  logic                  req_debug_region_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_err_o,
    output logic                  rsp_match_o,
    output logic [RIDX_W-1:0]     rsp_region_o,
    output logic                  busy_o
);
    localparam int RPC   = (PMP_NUM_REGIONS == 0) ? 1 : REGIONS_PER_CYCLE;
    localparam int NGRP  = (PMP_NUM_REGIONS == 0) ? 1 : PMP_NUM_REGIONS / RPC;
    localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;

    pmp_scan_state_e         state_q, state_d;
    logic [GRP_W-1:0]        grp_q, grp_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    pmp_req_e                type_q;
    privlvl_t                priv_q;
    logic                    err_q, err_d, match_q, match_d;
    logic [RIDX_W-1:0]       region_q, region_d;

    logic [RPC-1:0]          lane_match, lane_fault;
    logic [RPC-1:0][5:0]     lane_idx;
    logic                    hit, hit_fault;
    logic [5:0]              hit_idx;
    logic                    fast, sec_m;
    logic                    unused_csr;

    assign unused_csr = ^{csr_pmp_i.mseccfg.zero0, csr_pmp_i.mseccfg.rlb};

    for (genvar i = 0; i < RPC; i++) begin : g_lane
        assign lane_idx[i] = 6'(grp_q) * 6'(RPC) + 6'(i);

        cv32e40s_pmp_region_check #(
            .PMP_GRANULARITY (PMP_GRANULARITY),
            .ADDR_WIDTH      (ADDR_WIDTH)
        ) u_check (
            .cfg_i        (csr_pmp_i.cfg[lane_idx[i]]),
            .addr_i       (csr_pmp_i.addr[lane_idx[i]]),
            .prev_addr_i  (csr_pmp_i.addr[lane_idx[i] - 6'd1]),
            .is_region0_i (lane_idx[i] == 6'd0),
            .req_addr_i   (addr_q),
            .req_type_i   (type_q),
            .priv_lvl_i   (priv_q),
            .mml_i        (csr_pmp_i.mseccfg.mml),
            .match_o      (lane_match[i]),
            .fault_o      (lane_fault[i])
        );
    end

    // Descending walk so the lowest matching lane is the one left standing.
    always_comb begin
        hit       = 1'b0;
        hit_fault = 1'b0;
        hit_idx   = '0;
        for (int i = RPC - 1; i >= 0; i--) begin
            if (lane_match[i]) begin
                hit       = 1'b1;
                hit_fault = lane_fault[i];
                hit_idx   = lane_idx[i];
            end
        end
    end

    assign sec_m = (security_lvl_i == SECURITY_LVL_S) && (priv_lvl_i == PRIV_LVL_M);
    assign fast  = req_debug_region_i || sec_m || (PMP_NUM_REGIONS == 0);

    always_comb begin
        state_d  = state_q;
        grp_d    = grp_q;
        err_d    = err_q;
        match_d  = match_q;
        region_d = region_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    grp_d = '0;
                    if (fast) begin
                        state_d  = RESP;
                        match_d  = 1'b0;
                        region_d = '0;
                        err_d    = !req_debug_region_i && !sec_m &&
                                   pmp_default_fault(priv_lvl_i == PRIV_LVL_M,
                                                     csr_pmp_i.mseccfg, req_type_i);
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (csr_pmp_wr_i) begin
                    grp_d = '0;
                end else if (hit) begin
                    state_d  = RESP;
                    err_d    = hit_fault;
                    match_d  = 1'b1;
                    region_d = RIDX_W'(hit_idx);
                end else if (grp_q == GRP_W'(NGRP - 1)) begin
                    state_d  = RESP;
                    err_d    = pmp_default_fault(priv_q == PRIV_LVL_M,
                                                 csr_pmp_i.mseccfg, type_q);
                    match_d  = 1'b0;
                    region_d = '0;
                end else begin
                    grp_d = grp_q + GRP_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grp_q    <= '0;
            err_q    <= 1'b0;
            match_q  <= 1'b0;
            region_q <= '0;
            addr_q   <= '0;
            type_q   <= PMP_ACC_READ;
            priv_q   <= PRIV_LVL_M;
        end else begin
            state_q  <= state_d;
            grp_q    <= grp_d;
            err_q    <= err_d;
            match_q  <= match_d;
            region_q <= region_d;
            if (state_q == IDLE && req_valid_i) begin
                addr_q <= req_addr_i;
                type_q <= req_type_i;
                priv_q <= priv_lvl_i;
            end
        end
    end

    assign req_ready_o  = !rst && (state_q == IDLE);
    assign rsp_valid_o  = (state_q == RESP);
    assign rsp_err_o    = err_q;
    assign rsp_match_o  = match_q;
    assign rsp_region_o = region_q;
    assign busy_o       = (state_q != IDLE);

endmodule
